// File: rtl/cpu_pkg.sv
// Shared core types: instruction/PC widths, their typedefs, and the fetch FSM state encoding.
package cpu_pkg;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: buffered instruction, its PC, and valid/ready.
interface fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);

  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous load takes priority over increment; increment wraps.
module pc_reg #(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= START_ADDR;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, buffers one LUT word toward decode, and runs start/halt control.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = cpu_pkg::ADDR_W,
  parameter int                INSTR_W    = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [INSTR_W-1:0] lut_data,
  input  logic               br_take,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               halt_req,
  output logic               done,
  fetch_unit_if.master       dec
);

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               valid_q;

  logic              in_run;
  logic              advance;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_load_val;

  assign in_run  = (state == RUN);
  assign advance = !valid_q || dec.instr_ready;

  // Halt outranks branch, branch outranks sequential advance.
  assign pc_load     = (!in_run && start) || (in_run && !halt_req && br_take);
  assign pc_load_val = in_run ? br_target : START_ADDR;
  assign pc_inc      = in_run && !halt_req && !br_take && advance;

  pc_reg #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign lut_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (halt_req) begin
            valid_q <= 1'b0;
            done    <= 1'b1;
            state   <= HALT;
          end else if (br_take) begin
            // Flush the buffered word even if decode is ready this cycle.
            valid_q <= 1'b0;
          end else if (advance) begin
            instr_q    <= lut_data;
            instr_pc_q <= pc;
            valid_q    <= 1'b1;
          end
        end
        HALT: begin
          valid_q <= 1'b0;
          if (start) begin
            done  <= 1'b0;
            state <= RUN;
          end
        end
        default: begin
          valid_q <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign dec.instr       = instr_q;
  assign dec.instr_pc    = instr_pc_q;
  assign dec.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: LUT word[i] = 16'hA000 + i; decode acceptances checked in order.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct packed {
    instr_t instr;
    pc_t    pc;
  } exp_t;

  logic   clk;
  logic   rst_n;
  logic   start;
  logic   br_take;
  pc_t    br_target;
  logic   halt_req;
  logic   done;
  pc_t    lut_addr;
  instr_t lut_data;

  int total;
  int bad;
  exp_t exp_q[$];

  fetch_unit_if dec_if ();

  fetch_unit #(
    .ADDR_W     (ADDR_W),
    .INSTR_W    (INSTR_W),
    .START_ADDR ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .br_take   (br_take),
    .br_target (br_target),
    .halt_req  (halt_req),
    .done      (done),
    .dec       (dec_if.master)
  );

  assign lut_data = 16'hA000 + {7'd0, lut_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] ins, input logic [8:0] pc);
    exp_t e;
    e.instr = ins;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Apply inputs for the next rising edge, return 1 time unit after it.
  task automatic cyc(input logic st, input logic rdy, input logic br,
                     input logic [8:0] tgt, input logic hl);
    start              = st;
    dec_if.instr_ready = rdy;
    br_take            = br;
    br_target          = tgt;
    halt_req           = hl;
    @(posedge clk);
    #1;
  endtask

  // Decode model: a word is consumed when valid && ready and no flush/halt is pending.
  always @(negedge clk) begin
    if (rst_n && dec_if.instr_valid && dec_if.instr_ready && !br_take && !halt_req) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_accept: got instr=%0h pc=%0h expected none",
                 dec_if.instr, dec_if.instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("accept_instr", 32'(dec_if.instr), 32'(e.instr));
        chk("accept_pc", 32'(dec_if.instr_pc), 32'(e.pc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    br_take = 1'b0;
    br_target = '0;
    halt_req = 1'b0;
    dec_if.instr_ready = 1'b0;
    #22;
    chk("rst_valid", 32'(dec_if.instr_valid), 0);
    chk("rst_instr", 32'(dec_if.instr), 0);
    chk("rst_instr_pc", 32'(dec_if.instr_pc), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lut_addr", 32'(lut_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_no_fetch", 32'(dec_if.instr_valid), 0);

    // Test 1/2: sequential fetch, then a 3-cycle stall at instr_pc=2
    push(16'hA000, 9'd0); push(16'hA001, 9'd1); push(16'hA002, 9'd2);
    push(16'hA003, 9'd3); push(16'hA004, 9'd4);
    cyc(1, 0, 0, 0, 0);
    chk("start_valid", 32'(dec_if.instr_valid), 0);
    chk("start_pc", 32'(lut_addr), 0);
    cyc(0, 1, 0, 0, 0);
    chk("first_valid", 32'(dec_if.instr_valid), 1);
    chk("first_instr", 32'(dec_if.instr), 32'h0000A000);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("stall_instr", 32'(dec_if.instr), 32'h0000A002);
      chk("stall_lut_addr", 32'(lut_addr), 3);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    chk("run_done", 32'(done), 0);

    // Test 3: branch to 0x40 with A005 buffered and ready=1
    push(16'hA040, 9'h040); push(16'hA041, 9'h041);
    cyc(0, 1, 1, 9'h040, 0);
    chk("br_bubble", 32'(dec_if.instr_valid), 0);
    chk("br_lut_addr", 32'(lut_addr), 32'h40);
    cyc(0, 1, 0, 0, 0);
    chk("br_target_instr", 32'(dec_if.instr), 32'h0000A040);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Test 4: branch to the last address, PC wraps to 0
    push(16'hA1FF, 9'h1FF); push(16'hA000, 9'h000);
    cyc(0, 1, 1, 9'h1FF, 0);
    chk("wrap_lut_addr", 32'(lut_addr), 32'h1FF);
    cyc(0, 1, 0, 0, 0);
    chk("wrap_pc_zero", 32'(lut_addr), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);

    // Test 5: halt wins over a same-cycle branch; restart from 0
    cyc(0, 1, 1, 9'h080, 1);
    chk("halt_done", 32'(done), 1);
    chk("halt_valid", 32'(dec_if.instr_valid), 0);
    chk("halt_pc", 32'(lut_addr), 2);
    cyc(0, 1, 1, 9'h033, 0);
    chk("halt_ignore_br", 32'(lut_addr), 2);
    chk("halt_hold_valid", 32'(dec_if.instr_valid), 0);
    push(16'hA000, 9'd0); push(16'hA001, 9'd1);
    cyc(1, 0, 0, 0, 0);
    chk("restart_done", 32'(done), 0);
    chk("restart_pc", 32'(lut_addr), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pre_rst_stall", 32'(dec_if.instr), 32'h0000A002);

    // Test 6: asynchronous reset during a stall
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(dec_if.instr_valid), 0);
    chk("async_instr", 32'(dec_if.instr), 0);
    chk("async_instr_pc", 32'(dec_if.instr_pc), 0);
    chk("async_lut_addr", 32'(lut_addr), 0);
    chk("async_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(16'hA000, 9'd0); push(16'hA001, 9'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
